// File: rtl/led_pattern_gen_pkg.sv
// Shared encodings for the LED pattern generator: pattern modes and ping-pong direction.
package led_pattern_gen_pkg;

    typedef enum logic [1:0] {
        MODE_FLASH = 2'd0,
        MODE_ROT_L = 2'd1,
        MODE_ROT_R = 2'd2,
        MODE_PING  = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

endpackage

// File: rtl/led_pattern_gen_prescaler.sv
// Step-rate prescaler: free-running counter compared against a selectable limit.
// The step strobe is combinational so the pattern register can act on it in the same edge.
module led_prescaler
    import led_pattern_gen_pkg::*;
#(
    parameter int unsigned NB_COUNTER = 32,
    parameter int unsigned R0         = 2**23,
    parameter int unsigned R1         = 2**24,
    parameter int unsigned R2         = 2**25,
    parameter int unsigned R3         = 2**26
) (
    input  logic       clock,
    input  logic       i_reset,
    input  logic       valid,
    input  logic       clear,
    input  logic [1:0] period_sel,
    output logic       step
);

    logic [NB_COUNTER-1:0] counter;
    logic [NB_COUNTER-1:0] limit;
    logic [NB_COUNTER-1:0] limit_m1;

    // Select the step period for the current cycle.
    always_comb begin
        limit = NB_COUNTER'(R0);
        case (period_sel)
            2'd0:    limit = NB_COUNTER'(R0);
            2'd1:    limit = NB_COUNTER'(R1);
            2'd2:    limit = NB_COUNTER'(R2);
            default: limit = NB_COUNTER'(R3);
        endcase
    end

    assign limit_m1 = limit - NB_COUNTER'(1);

    // ">=" rather than "==" so a shrinking period still wraps on the next edge.
    assign step = valid & (counter >= limit_m1);

    // Counter: cleared on mode change or step, advances only while enabled.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            counter <= '0;
        end else if (clear) begin
            counter <= '0;
        end else if (step) begin
            counter <= '0;
        end else if (valid) begin
            counter <= counter + NB_COUNTER'(1);
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-mode LED pattern generator: flash, rotate left/right and ping-pong,
// advanced by a selectable-rate prescaler.
module led_pattern_gen
    import led_pattern_gen_pkg::*;
#(
    parameter int unsigned NB_LEDS    = 4,
    parameter int unsigned NB_COUNTER = 32,
    parameter int unsigned R0         = 2**23,
    parameter int unsigned R1         = 2**24,
    parameter int unsigned R2         = 2**25,
    parameter int unsigned R3         = 2**26
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic [1:0]         i_mode,
    input  logic [1:0]         i_period_sel,
    output logic [NB_LEDS-1:0] o_led,
    output logic               o_tick
);

    mode_t              mode_reg;
    mode_t              mode_next;
    mode_t              mode_in;
    dir_t               dir;
    dir_t               dir_next;
    logic [NB_LEDS-1:0] led_next;
    logic [NB_LEDS-1:0] shifted;
    logic               tick_next;
    logic               mode_change;
    logic               step;

    assign mode_in     = mode_t'(i_mode);
    assign mode_change = (mode_in != mode_reg);

    led_prescaler #(
        .NB_COUNTER (NB_COUNTER),
        .R0         (R0),
        .R1         (R1),
        .R2         (R2),
        .R3         (R3)
    ) u_prescaler (
        .clock      (clock),
        .i_reset    (i_reset),
        .valid      (i_valid),
        .clear      (mode_change),
        .period_sel (i_period_sel),
        .step       (step)
    );

    // Next pattern/direction/mode: a mode change overrides any pending step.
    always_comb begin
        mode_next = mode_reg;
        dir_next  = dir;
        led_next  = o_led;
        tick_next = 1'b0;
        shifted   = '0;
        if (mode_change) begin
            mode_next = mode_in;
            dir_next  = DIR_LEFT;
            if (mode_in == MODE_FLASH) begin
                led_next = '1;
            end else begin
                led_next = NB_LEDS'(1);
            end
        end else if (step) begin
            tick_next = 1'b1;
            case (mode_reg)
                MODE_FLASH: led_next = ~o_led;
                MODE_ROT_L: led_next = {o_led[NB_LEDS-2:0], o_led[NB_LEDS-1]};
                MODE_ROT_R: led_next = {o_led[0], o_led[NB_LEDS-1:1]};
                MODE_PING: begin
                    if (dir == DIR_LEFT) begin
                        shifted  = o_led << 1;
                        led_next = shifted;
                        if (shifted[NB_LEDS-1]) begin
                            dir_next = DIR_RIGHT;
                        end
                    end else begin
                        shifted  = o_led >> 1;
                        led_next = shifted;
                        if (shifted[0]) begin
                            dir_next = DIR_LEFT;
                        end
                    end
                end
                default: led_next = o_led;
            endcase
        end
    end

    // Pattern, tick, mode and direction registers.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            o_led    <= '1;
            o_tick   <= 1'b0;
            mode_reg <= MODE_FLASH;
            dir      <= DIR_LEFT;
        end else begin
            o_led    <= led_next;
            o_tick   <= tick_next;
            mode_reg <= mode_next;
            dir      <= dir_next;
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen (NB_LEDS=4, periods 4/8/16/32).
module tb_led_pattern_gen;

    localparam int NL = 4;

    logic       clock = 1'b0;
    logic       i_reset;
    logic       i_valid;
    logic [1:0] i_mode;
    logic [1:0] i_period_sel;
    logic [3:0] o_led;
    logic       o_tick;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pattern expressed as step index within the current mode.
    int m_mode = 0;
    int m_p    = 0;
    int m_cnt  = 0;
    bit m_tick = 1'b0;

    typedef struct {
        logic       rst;
        logic       vld;
        logic [1:0] mode;
        logic [1:0] sel;
        logic [3:0] led;
        logic       tick;
    } vec_t;

    vec_t tbl[$];

    led_pattern_gen #(
        .NB_LEDS    (NL),
        .NB_COUNTER (32),
        .R0         (4),
        .R1         (8),
        .R2         (16),
        .R3         (32)
    ) dut (
        .clock        (clock),
        .i_reset      (i_reset),
        .i_valid      (i_valid),
        .i_mode       (i_mode),
        .i_period_sel (i_period_sel),
        .o_led        (o_led),
        .o_tick       (o_tick)
    );

    always #5 clock = ~clock;

    function automatic int period_of(input logic [1:0] sel);
        int p;
        p = 4 << sel;
        return p;
    endfunction

    function automatic logic [3:0] model_led(input int mode, input int p);
        logic [3:0] one;
        int pos;
        int idx;
        one = 4'b0001;
        case (mode)
            0: return (p % 2 == 0) ? 4'b1111 : 4'b0000;
            1: return one << (p % NL);
            2: return one << ((NL - (p % NL)) % NL);
            default: begin
                pos = p % (2 * (NL - 1));
                idx = (pos < NL) ? pos : 2 * (NL - 1) - pos;
                return one << idx;
            end
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_p    = 0;
        m_cnt  = 0;
        m_tick = 1'b0;
    endtask

    // Apply one rising edge to the model using the inputs held across it.
    task automatic model_edge();
        if (i_reset) begin
            model_reset();
        end else if (int'(i_mode) != m_mode) begin
            m_mode = int'(i_mode);
            m_p    = 0;
            m_cnt  = 0;
            m_tick = 1'b0;
        end else if (i_valid) begin
            if (m_cnt + 1 >= period_of(i_period_sel)) begin
                m_p++;
                m_cnt  = 0;
                m_tick = 1'b1;
            end else begin
                m_cnt++;
                m_tick = 1'b0;
            end
        end else begin
            m_tick = 1'b0;
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        model_edge();
        #1;
        check("model_led", o_led, model_led(m_mode, m_p));
        check("model_tick", o_tick, m_tick);
    endtask

    task automatic add(input logic rst, input logic vld, input logic [1:0] mode,
                       input logic [1:0] sel, input logic [3:0] led, input logic tick);
        vec_t v;
        v.rst = rst; v.vld = vld; v.mode = mode; v.sel = sel; v.led = led; v.tick = tick;
        tbl.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] seq [8];
        logic [3:0] held;
        int gap;

        // Reset-then-flash and rotate-left vectors, one clock edge each.
        add(1'b1, 1'b1, 2'd0, 2'd0, 4'b1111, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            add(1'b0, 1'b1, 2'd0, 2'd0, (i < 4 || i == 8) ? 4'b1111 : 4'b0000, (i == 4 || i == 8));
        end
        add(1'b0, 1'b1, 2'd1, 2'd1, 4'b0001, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            add(1'b0, 1'b1, 2'd1, 2'd1, 4'b0001 << (k / 8), (k % 8 == 0));
        end

        i_reset = 1'b1; i_valid = 1'b1; i_mode = 2'd0; i_period_sel = 2'd0;
        #1;
        check("reset_led", o_led, 4'b1111);
        check("reset_tick", o_tick, 1'b0);

        foreach (tbl[i]) begin
            i_reset = tbl[i].rst; i_valid = tbl[i].vld;
            i_mode = tbl[i].mode; i_period_sel = tbl[i].sel;
            cyc();
            check($sformatf("vec%0d_led", i), o_led, tbl[i].led);
            check($sformatf("vec%0d_tick", i), o_tick, tbl[i].tick);
        end

        // Ping-pong: bounce sequence at 4-cycle spacing, never empty, never wrapping.
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        i_mode = 2'd3; i_period_sel = 2'd0; i_valid = 1'b1;
        cyc();
        check("ping_start", o_led, seq[0]);
        for (int s = 1; s < 8; s++) begin
            gap = 0;
            for (int c = 1; c <= 6; c++) begin
                cyc();
                gap = c;
                if (o_tick === 1'b1) break;
            end
            check($sformatf("ping_gap%0d", s), gap, 4);
            check($sformatf("ping_led%0d", s), o_led, seq[s]);
        end

        // Enable hold in rotate right with the counter at 2.
        i_mode = 2'd2;
        cyc();
        check("hold_start", o_led, 4'b0001);
        cyc();
        cyc();
        held = o_led;
        i_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            check("hold_led", o_led, held);
            check("hold_tick", o_tick, 1'b0);
        end
        i_valid = 1'b1;
        cyc();
        check("resume_tick1", o_tick, 1'b0);
        cyc();
        check("resume_tick2", o_tick, 1'b1);
        check("resume_led", o_led, 4'b1000);

        // Period shrink: long period for 20 cycles, then the shortest.
        i_mode = 2'd1; i_period_sel = 2'd3;
        cyc();
        for (int c = 0; c < 20; c++) cyc();
        check("shrink_pre", o_led, 4'b0001);
        i_period_sel = 2'd0;
        cyc();
        check("shrink_tick", o_tick, 1'b1);
        check("shrink_led", o_led, 4'b0010);
        for (int c = 1; c <= 4; c++) begin
            cyc();
            check("shrink_period_tick", o_tick, (c == 4));
        end
        check("shrink_led2", o_led, 4'b0100);

        // Asynchronous reset between edges while a tick is high in ping-pong.
        i_mode = 2'd3;
        cyc();
        for (int c = 0; c < 4; c++) cyc();
        check("async_pre_tick", o_tick, 1'b1);
        @(negedge clock);
        i_reset = 1'b1;
        #1;
        model_reset();
        check("async_led", o_led, 4'b1111);
        check("async_tick", o_tick, 1'b0);
        i_reset = 1'b0;
        cyc();
        check("async_mode_led", o_led, 4'b0001);

        // Randomized run against the model.
        for (int c = 0; c < 600; c++) begin
            i_reset = ($urandom_range(0, 199) == 0);
            i_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) i_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) i_period_sel = 2'($urandom_range(0, 3));
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Parametrised successor of the single-mode LED flasher. Drives NB_LEDS board LEDs with one of four patterns (flash, rotate left, rotate right, ping-pong). An internal prescaler advances the pattern at one of four selectable rates. Sits between the switch/button inputs and the board LED pins, one instance per LED bank.

Parameters:
NB_LEDS, 4, LED count; must be >= 2
NB_COUNTER, 32, prescaler counter width
R0, 2**23, prescaler limit for i_period_sel=0 (cycles per step)
R1, 2**24, prescaler limit for i_period_sel=1
R2, 2**25, prescaler limit for i_period_sel=2
R3, 2**26, prescaler limit for i_period_sel=3

Ports:
clock  input  1  system clock, all logic rising-edge
i_reset  input  1  asynchronous, active-high reset
i_valid  input  1  run enable; low freezes prescaler and pattern
i_mode  input  2  0 flash, 1 rotate left, 2 rotate right, 3 ping-pong
i_period_sel  input  2  selects step period R0..R3
o_led  output  NB_LEDS  registered LED pattern
o_tick  output  1  registered one-cycle pulse on every pattern step

Behaviour:
- Reset (i_reset high, asynchronous): o_led = all ones, o_tick = 0, counter = 0, mode_reg = 0, dir = left.
- Limit: limit = R[i_period_sel], sampled combinationally each cycle. All R values must be >= 2 and < 2**NB_COUNTER.
- Step condition: i_valid & (counter >= limit-1). On a step, counter <= 0.
- Counting: if i_valid and no step, counter <= counter+1. If i_valid is low, the counter holds.
- The ">=" compare guarantees a wrap when the period shrinks mid-count. Example: counter=10, new limit 4 -> step on the next edge.
- Mode change has priority over the step. If i_mode != mode_reg:
  - mode_reg <= i_mode, counter <= 0, dir <= left, o_tick <= 0.
  - o_led <= all ones for mode 0, or 1 at bit 0 (one-hot LSB) for modes 1-3.
  - Mode change applies regardless of i_valid.
- On a step, o_led updates and o_tick <= 1 in that same clock edge. Otherwise o_tick <= 0.
  - Flash: o_led <= ~o_led.
  - Rotate left: o_led <= {o_led[NB_LEDS-2:0], o_led[NB_LEDS-1]}.
  - Rotate right: o_led <= {o_led[0], o_led[NB_LEDS-1:1]}.
  - Ping-pong, dir=left: shift left 1. If the result has the MSB set, dir <= right.
  - Ping-pong, dir=right: shift right 1. If the result has bit 0 set, dir <= left.
  - Ping-pong never wraps. The sequence for 4 LEDs is 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, ...
- Latency: the first step after a reset release or mode change occurs limit cycles after counting starts (counter 0..limit-1).
- i_valid deasserted mid-period: counter and o_led hold. Counting resumes from the held value (no restart).
- Reset asserted mid-operation: immediate return to the reset values, independent of clock.
- i_mode and i_period_sel are assumed synchronous to clock; synchronisers belong upstream.

Decomposition:
- Shared package: mode encodings (MODE_FLASH=0, MODE_ROT_L=1, MODE_ROT_R=2, MODE_PING=3) and the direction constants DIR_LEFT/DIR_RIGHT.
- One sub-module: led_prescaler. Holds the counter, limit mux and compare, and outputs the step strobe. It has a synchronous clear input driven by the mode-change detect.
- The pattern register and ping-pong direction flop stay in led_pattern_gen.

Test Plan:
All tests use NB_LEDS=4, R0=4, R1=8, R2=16, R3=32.
- Reset then flash: i_reset pulse, i_valid=1, mode 0, sel 0 -> o_led=1111. o_led toggles 1111->0000->1111 every 4 cycles, with o_tick high one cycle per toggle.
- Rotate left: mode 1, sel 1 -> o_led=0001 on the cycle after the mode change. It then steps 0010, 0100, 1000, 0001 every 8 cycles.
- Ping-pong: mode 3, sel 0 -> the sequence 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010 occurs at 4-cycle spacing, with no 0000 and no wrap.
- Enable hold: in mode 2, drop i_valid for 20 cycles mid-period (counter=2) -> o_led and o_tick stay frozen. After reassert, the next step comes after 2 more cycles.
- Period shrink: sel 3, wait 20 cycles, switch to sel 0 -> a step occurs on the next edge, then every 4 cycles.
- Async reset mid-run: assert i_reset between clock edges in mode 3 -> o_led=1111 and o_tick=0 before the next edge. Mode returns to flash.
